// File: rtl/fabric_cfg_pkg.sv
// fabric_cfg_pkg
// Shared definitions for the configuration daisy chain: the loader FSM state
// encodings, the ordering of the fields inside a frame, and a helper that
// gives the length of one frame in clock cycles. The chain driver, the
// loaders and the benches all import this package so they agree on framing.
package fabric_cfg_pkg;

    // Loader FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_SKIP = 2'd3;

    // Frame layout: the address field precedes the data field, and both
    // fields are sent most-significant bit first.
    localparam bit ADDR_FIELD_FIRST = 1'b1;
    localparam bit ADDR_MSB_FIRST   = 1'b1;
    localparam bit DATA_MSB_FIRST   = 1'b1;

    // Number of serial bits (and therefore cycles) in one complete frame
    function automatic int frame_len(input int cfg_size, input int id_width);
        return cfg_size + id_width;
    endfunction

endpackage

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader
// One link of the configuration daisy chain. It watches the serial frame
// stream, and when a frame's address field equals ID it captures the data
// field into a shadow register and commits it to cfg in one step. Every bit
// is also forwarded, one cycle late, to the next loader in the chain.
//
// Ports
//   clk           : single clock, rising edge
//   rst_n         : asynchronous active-low reset
//   cfg_in_start  : marks the first (address MSB) bit of a frame
//   cfg_bit_in    : serial configuration bit, one per cycle
//   cfg_out_start : cfg_in_start delayed by one cycle (daisy chain)
//   cfg_bit_out   : cfg_bit_in delayed by one cycle (daisy chain)
//   cfg           : active configuration word for the CLB
//   cfg_load      : one-cycle pulse when cfg takes a new value
//   cfg_valid     : high once any frame has been committed since reset
module cfg_frame_loader
    import fabric_cfg_pkg::*;
#(
    parameter int CFG_SIZE = 256,
    parameter int ID_WIDTH = 3,
    parameter int ID       = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_in_start,
    input  logic                cfg_bit_in,
    output logic                cfg_out_start,
    output logic                cfg_bit_out,
    output logic [CFG_SIZE-1:0] cfg,
    output logic                cfg_load,
    output logic                cfg_valid
);

    localparam int CNT_W = $clog2(frame_len(CFG_SIZE, ID_WIDTH));

    localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ID_WIDTH - 1);
    localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(CFG_SIZE - 1);
    localparam logic [ID_WIDTH-1:0] MY_ID     = ID_WIDTH'(ID);

    logic [1:0]          state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [ID_WIDTH-1:0] addr_q,      addr_d;
    logic [CFG_SIZE-1:0] shadow_q,    shadow_d;
    logic [CFG_SIZE-1:0] cfg_q,       cfg_d;
    logic                cfg_load_q,  cfg_load_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                out_start_q;
    logic                bit_out_q;

    // Frame FSM. A start bit overrides whatever the FSM was doing, which is
    // what makes a mid-frame start abort the frame (even on what would have
    // been the last data bit) and a start in the commit cycle begin a new
    // frame. The counter counts bits within the current field.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        shadow_d    = shadow_q;
        cfg_d       = cfg_q;
        cfg_load_d  = 1'b0;
        cfg_valid_d = cfg_valid_q;

        if (cfg_in_start) begin
            addr_d   = ID_WIDTH'(cfg_bit_in);
            shadow_d = '0;
            if (ID_WIDTH == 1) begin
                state_d = (addr_d == MY_ID) ? ST_DATA : ST_SKIP;
                cnt_d   = '0;
            end else begin
                state_d = ST_ADDR;
                cnt_d   = CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_ADDR: begin
                    addr_d = (addr_q << 1) | ID_WIDTH'(cfg_bit_in);
                    if (cnt_q == ADDR_LAST) begin
                        state_d = (addr_d == MY_ID) ? ST_DATA : ST_SKIP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    // Shift left so the first data bit ends up in the MSB
                    shadow_d = (shadow_q << 1) | CFG_SIZE'(cfg_bit_in);
                    if (cnt_q == DATA_LAST) begin
                        cfg_d       = shadow_d;
                        cfg_load_d  = 1'b1;
                        cfg_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SKIP: begin
                    if (cnt_q == DATA_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            shadow_q    <= '0;
            cfg_q       <= '0;
            cfg_load_q  <= 1'b0;
            cfg_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            bit_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            cfg_load_q  <= cfg_load_d;
            cfg_valid_q <= cfg_valid_d;
            out_start_q <= cfg_in_start;
            bit_out_q   <= cfg_bit_in;
        end
    end

    assign cfg_out_start = out_start_q;
    assign cfg_bit_out   = bit_out_q;
    assign cfg           = cfg_q;
    assign cfg_load      = cfg_load_q;
    assign cfg_valid     = cfg_valid_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb_cfg_frame_loader
// Bench for cfg_frame_loader with CFG_SIZE=8, ID_WIDTH=3, ID=5. Each frame
// that should commit pushes its data and the cycle in which the load must
// appear onto a queue; a monitor running on the falling edge pops entries
// when cfg_load fires, checks cfg holds steady between loads, and checks
// the daisy-chain outputs are the inputs delayed by one cycle.
module tb_cfg_frame_loader;
    import fabric_cfg_pkg::*;

    localparam int CFG_SIZE = 8;
    localparam int ID_WIDTH = 3;
    localparam int ID       = 5;
    localparam int FLEN     = CFG_SIZE + ID_WIDTH;

    typedef struct {
        logic [CFG_SIZE-1:0] data;
        int                  cyc;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                cfgInStart;
    logic                cfgBitIn;
    logic                cfgOutStart;
    logic                cfgBitOut;
    logic [CFG_SIZE-1:0] cfg;
    logic                cfgLoad;
    logic                cfgValid;

    int   checks;
    int   errors;
    int   cyc;
    exp_t expQ[$];
    logic [CFG_SIZE-1:0] cfgModel;
    logic prevBit;
    logic prevStart;

    cfg_frame_loader #(
        .CFG_SIZE(CFG_SIZE),
        .ID_WIDTH(ID_WIDTH),
        .ID      (ID)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_in_start (cfgInStart),
        .cfg_bit_in   (cfgBitIn),
        .cfg_out_start(cfgOutStart),
        .cfg_bit_out  (cfgBitOut),
        .cfg          (cfg),
        .cfg_load     (cfgLoad),
        .cfg_valid    (cfgValid)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one serial bit and advance to just after the sampling edge
    task automatic applyStimulus(input logic start, input logic bitVal);
        cfgInStart = start;
        cfgBitIn   = bitVal;
        @(posedge clk);
        #1;
    endtask

    // Send the first nbits bits of a frame; a complete frame addressed to
    // this loader registers its expected commit one cycle after the last bit
    task automatic sendFrame(input logic [ID_WIDTH-1:0] addr, input logic [CFG_SIZE-1:0] data,
                             input int nbits);
        logic [FLEN-1:0] f;
        f = {addr, data};
        for (int i = 0; i < nbits; i++) begin
            if (i == FLEN - 1 && addr == ID_WIDTH'(ID)) begin
                expQ.push_back('{data: data, cyc: cyc + 1});
            end
            applyStimulus(i == 0, f[FLEN-1-i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0);
        end
    endtask

    // Falling-edge monitor: scoreboard for loads, hold check for cfg, and
    // the one-cycle delay of the daisy-chain outputs
    task automatic monitorStep();
        exp_t e;
        if (!rst_n) begin
            cfgModel  = '0;
            prevBit   = 1'b0;
            prevStart = 1'b0;
            return;
        end
        checkOutput("bit_out_delay", 32'(cfgBitOut), 32'(prevBit));
        checkOutput("start_out_delay", 32'(cfgOutStart), 32'(prevStart));
        prevBit   = cfgBitIn;
        prevStart = cfgInStart;
        if (cfgLoad) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_load", 32'(cfgLoad), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("load_cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("load_data", 32'(cfg), 32'(e.data));
                checkOutput("load_valid", 32'(cfgValid), 32'd1);
                cfgModel = e.data;
            end
        end else begin
            checkOutput("cfg_hold", 32'(cfg), 32'(cfgModel));
            if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                checkOutput("missed_load", 32'(cfgLoad), 32'd1);
                void'(expQ.pop_front());
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        cfgModel   = '0;
        prevBit    = 1'b0;
        prevStart  = 1'b0;
        rst_n      = 1'b0;
        cfgInStart = 1'b0;
        cfgBitIn   = 1'b0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cfg", 32'(cfg), 32'd0);
        checkOutput("rst_load", 32'(cfgLoad), 32'd0);
        checkOutput("rst_valid", 32'(cfgValid), 32'd0);
        checkOutput("rst_out_start", 32'(cfgOutStart), 32'd0);
        checkOutput("rst_bit_out", 32'(cfgBitOut), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Matching frame; cfg_valid must stay low until the commit cycle
        $display("[TB] matching frame 101 / 0xA5");
        sendFrame(3'b101, 8'hA5, FLEN - 1);
        checkOutput("pre_commit_valid", 32'(cfgValid), 32'd0);
        checkOutput("pre_commit_cfg", 32'(cfg), 32'd0);
        expQ.push_back('{data: 8'hA5, cyc: cyc + 1});
        applyStimulus(1'b0, 1'b1);
        checkOutput("match_load", 32'(cfgLoad), 32'd1);
        checkOutput("match_cfg", 32'(cfg), 32'hA5);
        idle(1);
        checkOutput("match_load_drop", 32'(cfgLoad), 32'd0);
        checkOutput("match_valid", 32'(cfgValid), 32'd1);
        idle(2);

        // Mismatched frame leaves cfg alone
        $display("[TB] mismatched frame 011 / 0x3C");
        sendFrame(3'b011, 8'h3C, FLEN);
        idle(3);
        checkOutput("mismatch_cfg", 32'(cfg), 32'hA5);

        // Abort mid-data, then abort exactly on the last data bit
        $display("[TB] aborted frames");
        sendFrame(3'b101, 8'hFF, 6);
        sendFrame(3'b101, 8'h12, FLEN);
        checkOutput("abort_cfg", 32'(cfg), 32'h12);
        idle(2);
        sendFrame(3'b101, 8'h77, FLEN - 1);
        sendFrame(3'b101, 8'h34, FLEN);
        checkOutput("abort_last_cfg", 32'(cfg), 32'h34);
        idle(2);

        // Back-to-back: second start lands in the first frame's commit cycle
        $display("[TB] back-to-back frames");
        sendFrame(3'b101, 8'h01, FLEN);
        checkOutput("b2b_first_cfg", 32'(cfg), 32'h01);
        sendFrame(3'b101, 8'h80, FLEN);
        checkOutput("b2b_second_cfg", 32'(cfg), 32'h80);
        idle(2);

        // Reset in the middle of the data field
        $display("[TB] reset mid-frame");
        sendFrame(3'b101, 8'h99, 5);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_cfg", 32'(cfg), 32'd0);
        checkOutput("midrst_valid", 32'(cfgValid), 32'd0);
        checkOutput("midrst_load", 32'(cfgLoad), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        sendFrame(3'b101, 8'h5A, FLEN);
        checkOutput("post_rst_cfg", 32'(cfg), 32'h5A);
        idle(2);

        // Idle noise must not disturb anything
        $display("[TB] idle noise");
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        end
        checkOutput("noise_cfg", 32'(cfg), 32'h5A);
        checkOutput("noise_valid", 32'(cfgValid), 32'd1);

        idle(3);
        checkOutput("pending_loads", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_frame_loader.md
CFG_FRAME_LOADER -- requirements
Module: cfg_frame_loader

Interface
REQ-001 Parameter: CFG_SIZE, 256, width of the configuration word delivered to one CLB.
REQ-002 Parameter: ID_WIDTH, 3, width of the frame address field.
REQ-003 Parameter: ID, 0, address this loader answers to.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: cfg_in_start  input  1  frame-start marker, qualifies the first bit of a frame.
REQ-007 Port: cfg_bit_in  input  1  serial configuration bit, one per cycle.
REQ-008 Port: cfg_out_start  output  1  registered copy of cfg_in_start, for the daisy chain.
REQ-009 Port: cfg_bit_out  output  1  registered copy of cfg_bit_in, for the daisy chain.
REQ-010 Port: cfg  output  CFG_SIZE  active configuration word driven into the CLB cfg input.
REQ-011 Port: cfg_load  output  1  one-cycle pulse in the cycle cfg takes a new value.
REQ-012 Port: cfg_valid  output  1  high once any frame has been committed since reset.

Function
REQ-013 Frame format: ID_WIDTH address bits, MSB first, then CFG_SIZE data bits, MSB first; one bit per clk cycle, no gaps.
REQ-014 The cycle with cfg_in_start=1 carries address bit ID_WIDTH-1 on cfg_bit_in.
REQ-015 States: IDLE, ADDR, DATA (address matched), SKIP (address mismatched); cfg_in_start forces entry into ADDR from any state.
REQ-016 The ADDR state leaves after the last address bit: to DATA if the assembled address equals ID, else to SKIP.
REQ-017 In DATA, bits shift into a shadow register; cfg is not disturbed during shifting.
REQ-018 The first data bit lands in cfg[CFG_SIZE-1]; the last lands in cfg[0].
REQ-019 After the last data bit is sampled, the next cycle presents the whole shadow on cfg, pulses cfg_load, sets cfg_valid, and returns to IDLE.
REQ-020 SKIP counts CFG_SIZE bits without capture, then returns to IDLE; it never asserts cfg_load.
REQ-021 The bit counter is $clog2(CFG_SIZE+ID_WIDTH) bits wide and is reloaded on every cfg_in_start.
REQ-022 A cfg_in_start mid-frame, including on the last data bit, aborts the current frame: no commit, shadow discarded, new frame begins with that bit.
REQ-023 A cfg_in_start in the commit cycle is legal: the commit completes and the new frame begins.
REQ-024 In IDLE, cfg_bit_in without a start is ignored.
REQ-025 cfg_out_start and cfg_bit_out equal their inputs delayed by exactly one cycle, for all frames, matched or not.
REQ-026 cfg holds its value indefinitely between commits.

Reset
REQ-027 Asserting rst_n=0 immediately forces: state=IDLE, counter=0, shadow=0, cfg=0, cfg_load=0, cfg_valid=0, cfg_out_start=0, cfg_bit_out=0.
REQ-028 Reset mid-frame discards the frame; the first cfg_in_start after deassertion is accepted normally.

Structure
REQ-029 State encodings and the frame-field ordering constants live in a shared package, fabric_cfg_pkg, that the chain driver and the benches also use.
REQ-030 The block is a single module; no sub-module is instantiated.

Verification (CFG_SIZE=8, ID_WIDTH=3, ID=5; start at cycle t0)
REQ-031 Matching frame: address 101, data 0xA5 in t3..t10 -> cfg=0xA5, cfg_load=1 in t11 only, cfg_valid=1 from t11.
REQ-032 Mismatched frame: address 011, data 0x3C -> cfg stays 0xA5, no cfg_load; cfg_bit_out replays the 11 bits delayed by one cycle.
REQ-033 Abort: frame with address 101 and data 0xFF; restart at t6 with address 101 and data 0x12 -> no commit from the first frame, cfg=0x12 at t17.
REQ-034 Back-to-back frames: first frame data 0x01 commits at t11; second start at t11 with data 0x80 -> cfg=0x01 at t11, cfg=0x80 at t22.
REQ-035 Reset mid-DATA: rst_n low at t5 -> cfg=0, cfg_valid=0, no cfg_load; a new frame after release with data 0x5A -> cfg=0x5A.
REQ-036 Idle noise: random cfg_bit_in with cfg_in_start=0 for 50 cycles -> cfg and cfg_valid unchanged.
